add_mul_mix_sched: RTL
======================

// Module: add_mul_mix_sched
// PURPOSE
//  Shares one multi-cycle add-multiply engine, Result = (a+b)*(c+d), between NREQ requesters.
//  Round-robin arbitration selects one requester; a shift-add datapath computes the result
//  over W cycles; the result is returned on a single valid/ready response channel tagged with
//  the requester id. Sits between operand producers and the consumer of the mixed result.
// PARAMETERS
//  W     4  operand width; sums are W bits, result is 2W bits
//  NREQ  3  number of requesters (>=2)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset, asynchronous, active-high
//  req_valid  in   NREQ     requester i presents operands
//  req_ready  out  NREQ     one-hot accept; bit i high => requester i handshakes this cycle
//  req_a      in   NREQ*W   operand a, requester i in bits [i*W +: W]; same packing for b, c, d
//  req_b      in   NREQ*W   operand b
//  req_c      in   NREQ*W   operand c
//  req_d      in   NREQ*W   operand d
//  res_valid  out  1        result available
//  res_ready  in   1        consumer accepts result
//  res_data   out  2W       ((a+b) mod 2^W) * ((c+d) mod 2^W)
//  res_id     out  $clog2(NREQ)  index of the requester that owns res_data
//  busy       out  1        high in any state other than IDLE
// BEHAVIOUR
//  Reset: state IDLE; req_ready=0, res_valid=0, res_data=0, res_id=0, busy=0; rr pointer=0.
//  Reset mid-operation: in-flight op is discarded with no response; pointer returns to 0.
//  States: IDLE -> MUL -> DONE -> IDLE.
//  IDLE: grant = first valid requester searching from pointer upward, wrapping at NREQ.
//   req_ready = grant when any req_valid, else 0. req_ready is combinational from req_valid
//   and pointer. Accept edge: s1=(a+b)[W-1:0], s2=(c+d)[W-1:0] (carries discarded),
//   acc=0, cnt=0, id=grant, pointer=(grant+1) mod NREQ, go to MUL.
//  MUL: one bit per cycle, LSB first: if s2[cnt], acc += s1<<cnt. cnt increments each cycle;
//   after W cycles go to DONE. req_ready=0.
//  DONE: res_valid=1; res_data=acc and res_id held stable until res_ready. On handshake go to
//   IDLE; res_valid drops the next cycle. req_ready=0 (no accept in DONE).
//  Latency: handshake in cycle t -> res_valid first high in cycle t+W+1.
//   Minimum issue interval is W+2 cycles.
//  res_ready=1 before DONE has no effect. Requester dropping req_valid without a handshake
//   has no effect. Requesters not granted are never accepted and must keep req_valid asserted.
//  The pointer advances only on accept, so an idle cycle does not change fairness.
//  All-valid steady state serves 0,1,2,0,...; a requester waits at most NREQ-1 ops.
//  Arithmetic: acc is 2W bits and cannot overflow ((2^W-1)^2 < 2^2W). All adds are unsigned.
// STRUCTURE
//  Package add_mul_mix_pkg: state enum {IDLE,MUL,DONE}; W/NREQ defaults;
//   ID_W=$clog2(NREQ) localparam.
//  Sub-module rr_arb (NREQ): inputs valid vector and pointer, output one-hot grant and
//   encoded index. Purely combinational.
//  Top holds the FSM, the operand/sum registers, the cnt counter, acc, and the pointer.
// TESTING (W=4, NREQ=3)
//  1 Single op: req0 a=9,b=8,c=3,d=4 -> s1=1,s2=7; res_data=7, res_id=0.
//    res_valid high exactly 5 cycles after the accept cycle.
//  2 Max operands: a=b=c=d=15 -> 14*14; res_data=196 (0xC4). Zero case: c=8,d=8 -> res_data=0.
//  3 Fairness: all three req_valid held, 6 ops back-to-back -> res_id sequence 0,1,2,0,1,2.
//    Each requester's own operands are reflected in its result.
//  4 Backpressure: res_ready=0 for 10 cycles in DONE -> res_valid/res_data/res_id stable,
//    req_ready=0 throughout. res_ready=1 -> IDLE next cycle and the next grant is issued.
//  5 Async reset mid-MUL: assert rst between clock edges at cnt=2 -> outputs clear immediately.
//    After release, no stale response appears and the first grant goes to req0.
//  6 Pointer wrap: only req2 valid, accept -> pointer=0. Then req0 and req2 both valid -> req0
//    granted first.

Source files
------------

// File: rtl/add_mul_mix_pkg.sv
// Shared types and default sizes for the add-multiply scheduler.
package add_mul_mix_pkg;

    localparam int W_DEF    = 4;
    localparam int NREQ_DEF = 3;
    localparam int ID_W     = $clog2(NREQ_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_mul_mix_sched_rr_arb.sv
// Round-robin arbiter: the first valid requester at or above the pointer wins,
// with the search wrapping from NREQ-1 back to 0. Purely combinational.
module rr_arb #(
    parameter  int NREQ = 3,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // Scan NREQ positions starting at the pointer; the first valid one wins.
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/add_mul_mix_sched.sv
// Shared (a+b)*(c+d) engine: round-robin arbitration over NREQ requesters,
// a one-bit-per-cycle shift-add multiplier, and a tagged valid/ready response.
//
// Handshake rules: a transfer happens on a rising clk edge where valid and
// ready are both high. req_ready is one-hot and only asserted in IDLE;
// res_valid, res_data and res_id are held stable until res_ready is seen.
module add_mul_mix_sched
    import add_mul_mix_pkg::*;
#(
    parameter  int W    = W_DEF,
    parameter  int NREQ = NREQ_DEF,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*W-1:0] req_c,
    input  logic [NREQ*W-1:0] req_d,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2*W-1:0]    res_data,
    output logic [IDW-1:0]    res_id,
    output logic              busy,
    output state_t            dbg_state
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t            state;
    logic [W-1:0]      s1;
    logic [W-1:0]      s2;
    logic [2*W-1:0]    acc;
    logic [2*W-1:0]    acc_next;
    logic [CW-1:0]     cnt;
    logic [IDW-1:0]    ptr;

    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    gidx;
    logic              gany;
    logic [W-1:0]      sum_ab;
    logic [W-1:0]      sum_cd;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    // Accept only from IDLE; reset also forces ready low while it is asserted.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst) begin
            req_ready = grant;
        end
    end

    // Operand sums of the granted requester, carries dropped to W bits.
    always_comb begin
        sum_ab = req_a[gidx*W +: W] + req_b[gidx*W +: W];
        sum_cd = req_c[gidx*W +: W] + req_d[gidx*W +: W];
    end

    // One multiplier step: add s1 shifted by cnt when bit cnt of s2 is set.
    always_comb begin
        acc_next = acc;
        if (s2[cnt]) begin
            acc_next = acc + ({{W{1'b0}}, s1} << cnt);
        end
    end

    assign dbg_state = state;

    // Scheduler FSM with registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            s1        <= '0;
            s2        <= '0;
            acc       <= '0;
            cnt       <= '0;
            ptr       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gany) begin
                        s1     <= sum_ab;
                        s2     <= sum_cd;
                        acc    <= '0;
                        cnt    <= '0;
                        res_id <= gidx;
                        ptr    <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
                        busy   <= 1'b1;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        res_data  <= acc_next;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
